// File: rtl/hms_mode_ctrl.sv
// hms_mode_ctrl: button debounce, mode/position sequencing, counter increment
// enables and digit blink mask for the HMS clock datapath. Single clock domain.
module hms_mode_ctrl #(
  parameter int unsigned TICK_DIV  = 50000000,
  parameter int unsigned DEB_CYC   = 500000,
  parameter int unsigned BLINK_DIV = 12500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sw0,
  input  logic       i_sw1,
  input  logic       i_sw2,
  input  logic [5:0] i_sec_cnt,
  input  logic [5:0] i_min_cnt,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic       o_sec_inc,
  output logic       o_min_inc,
  output logic       o_hour_inc,
  output logic       o_alm_min_inc,
  output logic       o_alm_hour_inc,
  output logic [5:0] o_blink
);

  localparam int unsigned TW = $clog2(TICK_DIV);
  localparam int unsigned DW = $clog2(DEB_CYC + 1);
  localparam int unsigned BW = $clog2(BLINK_DIV);

  typedef enum logic [1:0] {M_CLOCK = 2'd0, M_SETUP = 2'd1, M_ALARM = 2'd2, M_BAD = 2'd3} mode_e;
  typedef enum logic [1:0] {P_SEC = 2'd0, P_MIN = 2'd1, P_HOUR = 2'd2, P_BAD = 2'd3} pos_e;

  logic [2:0]    raw;
  logic [2:0]    sync1;
  logic [2:0]    sync2;
  logic [2:0]    deb;
  logic [DW-1:0] deb_cnt [3];
  logic [2:0]    deb_done;
  logic [2:0]    press;

  mode_e         mode_q, mode_d;
  pos_e          pos_q, pos_d;
  logic [TW-1:0] tick_cnt;
  logic          tick_run;
  logic          tick;
  logic [BW-1:0] blink_cnt, blink_cnt_d;
  logic          phase, phase_d;
  logic          sec_inc_d, min_inc_d, hour_inc_d, alm_min_inc_d, alm_hour_inc_d;
  logic [5:0]    blink_d;

  assign raw = {i_sw2, i_sw1, i_sw0};

  // Two-flop synchronisers and per-button stability counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
      deb   <= 3'b111;
      for (int i = 0; i < 3; i++) deb_cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_done[i]) begin
          deb[i]     <= sync2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DW'(1);
        end
      end
    end
  end

  // A press is the cycle a debounced level commits from released to pressed.
  always_comb begin
    deb_done = '0;
    press    = '0;
    for (int i = 0; i < 3; i++) begin
      deb_done[i] = (sync2[i] != deb[i]) && (deb_cnt[i] == DW'(DEB_CYC - 1));
      press[i]    = deb_done[i] & ~sync2[i];
    end
  end

  assign tick_run = (mode_q == M_CLOCK) || (mode_q == M_ALARM);
  assign tick     = tick_run && (tick_cnt == TW'(TICK_DIV - 1));

  // Next mode/position, increment enables and blink mask.
  always_comb begin
    mode_d         = mode_q;
    pos_d          = pos_q;
    sec_inc_d      = 1'b0;
    min_inc_d      = 1'b0;
    hour_inc_d     = 1'b0;
    alm_min_inc_d  = 1'b0;
    alm_hour_inc_d = 1'b0;
    blink_cnt_d    = blink_cnt;
    phase_d        = phase;
    blink_d        = '0;

    if (tick) begin
      sec_inc_d  = 1'b1;
      min_inc_d  = (i_sec_cnt == 6'd59);
      hour_inc_d = (i_sec_cnt == 6'd59) && (i_min_cnt == 6'd59);
    end

    if ((mode_q == M_BAD) || (pos_q == P_BAD)) begin
      mode_d = M_CLOCK;
      pos_d  = P_SEC;
    end else if (press[0]) begin
      // Mode change takes priority; a coincident increment press is dropped.
      case (mode_q)
        M_CLOCK: begin mode_d = M_SETUP; pos_d = P_SEC; end
        M_SETUP: begin mode_d = M_ALARM; pos_d = P_MIN; end
        default: begin mode_d = M_CLOCK; pos_d = P_SEC; end
      endcase
    end else begin
      // Increment targets the position held before any coincident advance.
      if (press[2]) begin
        if (mode_q == M_SETUP) begin
          case (pos_q)
            P_SEC:   sec_inc_d  = 1'b1;
            P_MIN:   min_inc_d  = 1'b1;
            default: hour_inc_d = 1'b1;
          endcase
        end else if (mode_q == M_ALARM) begin
          if (pos_q == P_HOUR) alm_hour_inc_d = 1'b1;
          else                 alm_min_inc_d  = 1'b1;
        end
      end
      if (press[1]) begin
        if (mode_q == M_SETUP) begin
          case (pos_q)
            P_SEC:   pos_d = P_MIN;
            P_MIN:   pos_d = P_HOUR;
            default: pos_d = P_SEC;
          endcase
        end else if (mode_q == M_ALARM) begin
          pos_d = (pos_q == P_MIN) ? P_HOUR : P_MIN;
        end
      end
    end

    if ((mode_d != mode_q) || (pos_d != pos_q)) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase;
    end else begin
      blink_cnt_d = blink_cnt + BW'(1);
    end

    if ((mode_d == M_SETUP) || (mode_d == M_ALARM)) begin
      case (pos_d)
        P_SEC:   blink_d = {4'b0000, {2{phase_d}}};
        P_MIN:   blink_d = {2'b00, {2{phase_d}}, 2'b00};
        P_HOUR:  blink_d = {{2{phase_d}}, 4'b0000};
        default: blink_d = '0;
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mode_q         <= M_CLOCK;
      pos_q          <= P_SEC;
      tick_cnt       <= '0;
      blink_cnt      <= '0;
      phase          <= 1'b0;
      o_sec_inc      <= 1'b0;
      o_min_inc      <= 1'b0;
      o_hour_inc     <= 1'b0;
      o_alm_min_inc  <= 1'b0;
      o_alm_hour_inc <= 1'b0;
      o_blink        <= '0;
    end else begin
      mode_q         <= mode_d;
      pos_q          <= pos_d;
      tick_cnt       <= (tick || !tick_run) ? '0 : tick_cnt + TW'(1);
      blink_cnt      <= blink_cnt_d;
      phase          <= phase_d;
      o_sec_inc      <= sec_inc_d;
      o_min_inc      <= min_inc_d;
      o_hour_inc     <= hour_inc_d;
      o_alm_min_inc  <= alm_min_inc_d;
      o_alm_hour_inc <= alm_hour_inc_d;
      o_blink        <= blink_d;
    end
  end

  assign o_mode     = mode_q;
  assign o_position = pos_q;

endmodule

// File: tb/tb_hms_mode_ctrl.sv
// tb_hms_mode_ctrl: directed and randomized checks of hms_mode_ctrl against a
// behavioural model of the button/mode/tick/blink rules.
module tb_hms_mode_ctrl;

  localparam int unsigned TICK = 10;
  localparam int unsigned DEB  = 4;
  localparam int unsigned BLK  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sw0 = 1'b1, sw1 = 1'b1, sw2 = 1'b1;
  logic [5:0] sec_cnt = 6'd5, min_cnt = 6'd5;
  logic [1:0] o_mode, o_position;
  logic       o_sec_inc, o_min_inc, o_hour_inc, o_alm_min_inc, o_alm_hour_inc;
  logic [5:0] o_blink;

  hms_mode_ctrl #(.TICK_DIV(TICK), .DEB_CYC(DEB), .BLINK_DIV(BLK)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_sw0(sw0), .i_sw1(sw1), .i_sw2(sw2),
    .i_sec_cnt(sec_cnt), .i_min_cnt(min_cnt),
    .o_mode(o_mode), .o_position(o_position),
    .o_sec_inc(o_sec_inc), .o_min_inc(o_min_inc), .o_hour_inc(o_hour_inc),
    .o_alm_min_inc(o_alm_min_inc), .o_alm_hour_inc(o_alm_hour_inc),
    .o_blink(o_blink)
  );

  initial forever #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit started = 1'b0;

  // Behavioural model state.
  logic [2:0] rawq[$];
  logic [2:0] viewq[$];
  int         since[3];
  bit         m_deb[3];
  int         m_mode, m_pos, m_tcnt, m_bcnt, m_phase;
  bit         e_sec, e_min, e_hour, e_amin, e_ahour;
  logic [5:0] e_blink;

  task automatic model_reset();
    rawq.delete();
    viewq.delete();
    rawq.push_back(3'b111);
    rawq.push_back(3'b111);
    for (int i = 0; i < 3; i++) begin since[i] = 0; m_deb[i] = 1'b1; end
    m_mode = 0; m_pos = 0; m_tcnt = 0; m_bcnt = 0; m_phase = 0;
    e_sec = 0; e_min = 0; e_hour = 0; e_amin = 0; e_ahour = 0;
    e_blink = '0;
  endtask

  // One clock edge of the model: a button level flips once the input seen two
  // edges late has disagreed with it for DEB straight samples.
  task automatic model_step();
    bit p[3];
    bit tick, ok;
    int nm, np;
    logic [2:0] sv;
    if (!rst_n) begin
      model_reset();
      return;
    end
    rawq.push_back({sw2, sw1, sw0});
    sv = rawq[rawq.size() - 3];
    viewq.push_back(sv);
    for (int i = 0; i < 3; i++) begin
      p[i] = 1'b0;
      ok = (viewq.size() - since[i]) >= DEB;
      if (ok)
        for (int k = 1; k <= DEB; k++)
          if (viewq[viewq.size() - k][i] == m_deb[i]) ok = 1'b0;
      if (ok) begin
        m_deb[i] = ~m_deb[i];
        since[i] = viewq.size();
        p[i] = (m_deb[i] == 1'b0);
      end
    end
    e_sec = 0; e_min = 0; e_hour = 0; e_amin = 0; e_ahour = 0;
    tick = (m_mode != 1) && (m_tcnt == TICK - 1);
    if (tick) begin
      e_sec  = 1;
      e_min  = (sec_cnt == 59);
      e_hour = (sec_cnt == 59) && (min_cnt == 59);
    end
    nm = m_mode; np = m_pos;
    if (p[0]) begin
      nm = (m_mode + 1) % 3;
      np = (nm == 2) ? 1 : 0;
    end else begin
      if (p[2] && m_mode == 1) begin
        if (m_pos == 0) e_sec = 1; else if (m_pos == 1) e_min = 1; else e_hour = 1;
      end
      if (p[2] && m_mode == 2) begin
        if (m_pos == 2) e_ahour = 1; else e_amin = 1;
      end
      if (p[1] && m_mode == 1) np = (m_pos + 1) % 3;
      if (p[1] && m_mode == 2) np = 3 - m_pos;
    end
    m_tcnt = (m_mode == 1) ? 0 : (m_tcnt + 1) % TICK;
    if (nm != m_mode || np != m_pos) begin
      m_bcnt = 0; m_phase = 0;
    end else begin
      m_bcnt++;
      if (m_bcnt == BLK) begin m_bcnt = 0; m_phase ^= 1; end
    end
    m_mode = nm; m_pos = np;
    e_blink = (m_mode != 0 && m_phase != 0) ? 6'(3 << (2 * m_pos)) : 6'd0;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of every output against the model.
  initial forever begin
    @(negedge clk);
    if (started) begin
      n_tests++;
      if ({o_mode, o_position, o_sec_inc, o_min_inc, o_hour_inc, o_alm_min_inc, o_alm_hour_inc, o_blink} !==
          {2'(m_mode), 2'(m_pos), e_sec, e_min, e_hour, e_amin, e_ahour, e_blink}) begin
        n_fail++;
        $display("FAIL cycle_cmp t=%0t got mode=%0d pos=%0d inc=%b%b%b%b%b blink=%b exp mode=%0d pos=%0d inc=%b%b%b%b%b blink=%b",
                 $time, o_mode, o_position, o_sec_inc, o_min_inc, o_hour_inc, o_alm_min_inc, o_alm_hour_inc, o_blink,
                 m_mode, m_pos, e_sec, e_min, e_hour, e_amin, e_ahour, e_blink);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  int c_sec, c_min, c_hour, c_amin, c_ahour, c_blk_bad, c_blk_on;
  logic [5:0] blk_pat;

  task automatic clr();
    c_sec = 0; c_min = 0; c_hour = 0; c_amin = 0; c_ahour = 0; c_blk_bad = 0; c_blk_on = 0;
  endtask

  task automatic watch(input int n);
    repeat (n) begin
      @(negedge clk);
      c_sec   += int'(o_sec_inc);
      c_min   += int'(o_min_inc);
      c_hour  += int'(o_hour_inc);
      c_amin  += int'(o_alm_min_inc);
      c_ahour += int'(o_alm_hour_inc);
      if (o_blink == blk_pat) c_blk_on++;
      else if (o_blink != 6'd0) c_blk_bad++;
    end
  endtask

  task automatic press(input logic [2:0] mask, input int low, input int high);
    {sw2, sw1, sw0} = ~mask;
    watch(low);
    {sw2, sw1, sw0} = 3'b111;
    watch(high);
  endtask

  initial begin
    int k;
    bit found;
    blk_pat = 6'b000011;
    repeat (3) @(negedge clk);
    started = 1'b1;
    chk("reset_mode", int'(o_mode), 0);
    chk("reset_outs", int'({o_sec_inc, o_min_inc, o_hour_inc, o_alm_min_inc, o_alm_hour_inc, o_blink}), 0);
    rst_n = 1'b1;

    // Idle timekeeping.
    clr(); watch(40);
    chk("idle_sec_pulses", c_sec, 4);
    chk("idle_min_hour", c_min + c_hour, 0);

    // Full carry at 59:59.
    sec_cnt = 6'd59; min_cnt = 6'd59;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (o_sec_inc) found = 1'b1;
    end
    chk("carry_tick_seen", int'(found), 1);
    chk("carry_min_hour", int'({o_min_inc, o_hour_inc}), 3);
    sec_cnt = 6'd5; min_cnt = 6'd5;
    @(negedge clk);
    chk("carry_one_cycle", int'({o_sec_inc, o_min_inc, o_hour_inc}), 0);

    // Bouncy mode press.
    sw0 = 0; watch(2); sw0 = 1; watch(2); sw0 = 0; watch(6); sw0 = 1; watch(12);
    chk("bounce_mode_setup", int'(o_mode), 1);
    clr(); watch(24);
    chk("setup_no_tick", c_sec, 0);
    chk("setup_blink_sec_bad", c_blk_bad, 0);
    chk("setup_blink_sec_on", int'(c_blk_on >= 8), 1);

    // SETUP: two position presses, then an increment on HOUR.
    press(3'b010, 8, 8); chk("setup_pos_min", int'(o_position), 1);
    press(3'b010, 8, 8); chk("setup_pos_hour", int'(o_position), 2);
    clr(); press(3'b100, 8, 8);
    chk("setup_hour_inc", c_hour, 1);
    chk("setup_other_inc", c_sec + c_min, 0);
    blk_pat = 6'b110000; clr(); watch(20);
    chk("setup_blink_hour_bad", c_blk_bad, 0);
    chk("setup_blink_hour_on", int'(c_blk_on >= 4), 1);

    // ALARM.
    press(3'b001, 8, 8);
    chk("alarm_mode", int'(o_mode), 2);
    chk("alarm_pos_min", int'(o_position), 1);
    clr(); watch(20); chk("alarm_ticks", c_sec, 2);
    clr(); press(3'b100, 8, 8);
    chk("alarm_min_inc", c_amin, 1);
    chk("alarm_hour_inc0", c_ahour, 0);
    press(3'b010, 8, 8); chk("alarm_pos_hour", int'(o_position), 2);
    clr(); press(3'b100, 8, 8); chk("alarm_hour_inc", c_ahour, 1);

    // Back to CLOCK then SETUP; simultaneous mode + increment press.
    press(3'b001, 8, 8);
    chk("clock_mode", int'(o_mode), 0);
    chk("clock_pos", int'(o_position), 0);
    press(3'b001, 8, 8); chk("setup_again", int'(o_mode), 1);
    clr(); press(3'b101, 8, 2);
    chk("simul_mode_alarm", int'(o_mode), 2);
    chk("simul_no_inc", c_sec + c_min + c_hour + c_amin + c_ahour, 0);
    watch(12);

    // One-cycle reset mid-operation.
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_mode_pos", int'({o_mode, o_position}), 0);
    chk("midrst_outs", int'({o_sec_inc, o_min_inc, o_hour_inc, o_alm_min_inc, o_alm_hour_inc, o_blink}), 0);
    rst_n = 1'b1;
    k = 0; found = 1'b0;
    while (k < 30 && !found) begin
      @(negedge clk);
      k++;
      if (o_sec_inc) found = 1'b1;
    end
    chk("midrst_first_tick", k, 10);

    // Randomized button activity, bounce and carries.
    for (int it = 0; it < 300; it++) begin
      logic [2:0] mask;
      int low, high;
      mask = 3'($urandom_range(0, 7));
      low  = $urandom_range(1, 12);
      high = $urandom_range(1, 14);
      for (int c = 0; c < low + high; c++) begin
        if (c < low) {sw2, sw1, sw0} = ~mask ^ (($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'b000);
        else         {sw2, sw1, sw0} = 3'b111;
        sec_cnt = ($urandom_range(0, 2) == 0) ? 6'd59 : 6'($urandom_range(0, 59));
        min_cnt = ($urandom_range(0, 2) == 0) ? 6'd59 : 6'($urandom_range(0, 59));
        rst_n   = ($urandom_range(0, 499) == 0) ? 1'b0 : 1'b1;
        @(negedge clk);
      end
    end
    rst_n = 1'b1;
    {sw2, sw1, sw0} = 3'b111;
    repeat (5) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
